memory_arbiter: RTL and testbench

- Arbitrates the single unified RAM port between the instruction-fetch and data-memory (LW/SW) requesters of the datapath.
- Sequences each RAM access through a grant FSM and returns per-requester wait and load signals.
- Prevents instruction-fetch starvation under back-to-back data traffic and bounds stalled accesses with a timeout.
- Sits between the datapath/request logic and the RAM model; uses cpu_types_pkg word_t (32 bits) and ramstate_t.

---
 rtl/memory_arbiter.sv | 137 +++++++++++++
 tb/tb_memory_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// Unified RAM port arbiter for instruction fetch and data access.
// Grant FSM with fetch anti-starvation and stalled-access timeout.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {
    FREE, BUSY, ACCESS, ERROR
  } ramstate_t;
endpackage

module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  output logic      ierr,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      derr,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TLAST =
    TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE, IFETCH, DREAD, DWRITE
  } state_t;

  state_t        state, nstate;
  logic [SW-1:0] scnt, scnt_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic          live, acc, err, tmo;

  // state, starvation and timeout registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      scnt  <= '0;
      tcnt  <= '0;
    end else begin
      state <= nstate;
      scnt  <= scnt_n;
      tcnt  <= tcnt_n;
    end
  end

  // grant selection, RAM drive and requester responses
  always_comb begin
    nstate   = state;
    scnt_n   = scnt;
    tcnt_n   = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    ierr     = 1'b0;
    derr     = 1'b0;
    iload    = '0;
    dload    = '0;
    live     = 1'b0;
    acc      = (ramstate == ACCESS);
    err      = (ramstate == ERROR);
    tmo      = TO_EN && (tcnt == TLAST) && !acc && !err;
    unique case (state)
      IDLE: begin
        priority case (1'b1)
          iREN && (scnt >= SLIM): nstate = IFETCH;
          dWEN:                   nstate = DWRITE;
          dREN:                   nstate = DREAD;
          iREN:                   nstate = IFETCH;
          default:                nstate = IDLE;
        endcase
        if (nstate == IFETCH)
          scnt_n = '0;
        else if (nstate != IDLE && iREN && scnt < SLIM)
          scnt_n = scnt + 1'b1;
      end
      default: begin
        live = (state == IFETCH) ? iREN :
               (state == DREAD)  ? dREN : dWEN;
        if (!live) begin
          nstate = IDLE;
        end else begin
          if (!tmo) begin
            ramREN  = (state != DWRITE);
            ramWEN  = (state == DWRITE);
            ramaddr = (state == IFETCH) ? iaddr : daddr;
            if (state == DWRITE)
              ramstore = dstore;
          end
          if (acc) begin
            nstate = IDLE;
            if (state == IFETCH) begin
              iwait = 1'b0;
              iload = ramload;
            end else begin
              dwait = 1'b0;
              dload = ramload;
            end
          end else if (err || tmo) begin
            nstate = IDLE;
            if (state == IFETCH)
              ierr = 1'b1;
            else
              derr = 1'b1;
          end else begin
            tcnt_n = tcnt + 1'b1;
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios then random traffic,
// each cycle compared against a transaction-level reference model.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  localparam int SL = 4;
  localparam int TO = 64;

  logic      CLK = 1'b0;
  logic      nRST;
  logic      iREN, dREN, dWEN;
  word_t     iaddr, daddr, dstore, ramload;
  logic      iwait, ierr, dwait, derr;
  word_t     iload, dload, ramaddr, ramstore;
  logic      ramREN, ramWEN;
  ramstate_t ramstate;

  int checks = 0;
  int errors = 0;

  // reference: who owns the port, granted cycles so far,
  // and how many data grants in a row bypassed a waiting fetch
  int own = 0;
  int age = 0;
  int streak = 0;
  int n_own, n_age, n_streak;

  logic  e_iwait, e_dwait, e_ierr, e_derr, e_ren, e_wen;
  word_t e_iload, e_dload, e_addr, e_store;

  memory_arbiter #(
    .STARVE_LIMIT(SL),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload), .ierr(ierr),
    .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload), .derr(derr),
    .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] o,
                     input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  function automatic void model_reset();
    own = 0;
    age = 0;
    streak = 0;
  endfunction

  function automatic void model_eval();
    bit live, last;
    e_iwait = 1; e_dwait = 1; e_ierr = 0; e_derr = 0;
    e_ren = 0; e_wen = 0;
    e_iload = 0; e_dload = 0; e_addr = 0; e_store = 0;
    n_own = 0; n_age = 0; n_streak = streak;
    if (own == 0) begin
      if (iREN && streak >= SL) n_own = 1;
      else if (dWEN) n_own = 3;
      else if (dREN) n_own = 2;
      else if (iREN) n_own = 1;
      if (n_own == 1) n_streak = 0;
      else if (n_own > 1 && iREN)
        n_streak = (streak < SL) ? streak + 1 : SL;
    end else begin
      live = (own == 1) ? iREN : (own == 2) ? dREN : dWEN;
      if (live) begin
        last = (age + 1 == TO) && ramstate != ACCESS
               && ramstate != ERROR;
        if (!last) begin
          e_ren = (own != 3);
          e_wen = (own == 3);
          e_addr = (own == 1) ? iaddr : daddr;
          e_store = (own == 3) ? dstore : 0;
        end
        if (ramstate == ACCESS) begin
          if (own == 1) begin
            e_iwait = 0; e_iload = ramload;
          end else begin
            e_dwait = 0; e_dload = ramload;
          end
        end else if (ramstate == ERROR || last) begin
          if (own == 1) e_ierr = 1;
          else e_derr = 1;
        end else begin
          n_own = own;
          n_age = age + 1;
        end
      end
    end
  endfunction

  task automatic settle();
    @(negedge CLK);
    model_eval();
    chk("iwait", 32'(iwait), 32'(e_iwait));
    chk("dwait", 32'(dwait), 32'(e_dwait));
    chk("ierr", 32'(ierr), 32'(e_ierr));
    chk("derr", 32'(derr), 32'(e_derr));
    chk("ramREN", 32'(ramREN), 32'(e_ren));
    chk("ramWEN", 32'(ramWEN), 32'(e_wen));
    chk("iload", iload, e_iload);
    chk("dload", dload, e_dload);
    chk("ramaddr", ramaddr, e_addr);
    chk("ramstore", ramstore, e_store);
  endtask

  task automatic adv();
    own = n_own;
    age = n_age;
    streak = n_streak;
    @(posedge CLK);
    #1;
  endtask

  task automatic tick();
    settle();
    adv();
  endtask

  initial begin
    int nd;
    bit got;
    int r;
    nRST = 0; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
    ramstate = FREE;
    #1;
    chk("rst_ren", 32'(ramREN), 0);
    chk("rst_wen", 32'(ramWEN), 0);
    chk("rst_iwait", 32'(iwait), 1);
    chk("rst_dwait", 32'(dwait), 1);
    @(posedge CLK); #1;
    nRST = 1;
    model_reset();
    tick();

    // reset in the middle of a write
    dWEN = 1; daddr = 32'h100; dstore = 32'hdead_beef;
    ramstate = BUSY;
    tick();
    settle();
    chk("dw_wen", 32'(ramWEN), 1);
    chk("dw_store", ramstore, 32'hdead_beef);
    adv();
    #2 nRST = 0;
    #1;
    chk("mid_rst_wen", 32'(ramWEN), 0);
    chk("mid_rst_dwait", 32'(dwait), 1);
    model_reset();
    dWEN = 0;
    nRST = 1;
    tick();
    settle();
    chk("post_rst_ren", 32'(ramREN), 0);
    chk("post_rst_wen", 32'(ramWEN), 0);
    adv();

    // single fetch, ACCESS on the second granted cycle
    iREN = 1; iaddr = 32'h40; ramload = 32'h2401_0005;
    tick();
    settle();
    chk("if_c2_ren", 32'(ramREN), 1);
    chk("if_c2_iwait", 32'(iwait), 1);
    adv();
    ramstate = ACCESS;
    settle();
    chk("if_c3_iwait", 32'(iwait), 0);
    chk("if_c3_iload", iload, 32'h2401_0005);
    chk("if_c3_addr", ramaddr, 32'h40);
    adv();
    iREN = 0; ramstate = FREE;
    settle();
    chk("if_c4_iwait", 32'(iwait), 1);
    chk("if_c4_iload", iload, 0);
    adv();

    // all three requests at once: write, then read, then fetch
    iREN = 1; dREN = 1; dWEN = 1; ramstate = BUSY;
    daddr = 32'h200; dstore = 32'h1234_5678; iaddr = 32'h44;
    tick();
    ramstate = ACCESS;
    settle();
    chk("sim_wen", 32'(ramWEN), 1);
    chk("sim_store", ramstore, 32'h1234_5678);
    chk("sim_wdone", 32'(dwait), 0);
    adv();
    dWEN = 0;
    settle();
    chk("sim_idle_ren", 32'(ramREN), 0);
    adv();
    settle();
    chk("sim_rd_ren", 32'(ramREN), 1);
    chk("sim_rd_addr", ramaddr, 32'h200);
    adv();
    dREN = 0;
    tick();
    settle();
    chk("sim_if_addr", ramaddr, 32'h44);
    chk("sim_if_done", 32'(iwait), 0);
    adv();
    iREN = 0;
    tick();

    // back-to-back reads must not starve a pending fetch
    iREN = 1; dREN = 1; ramstate = ACCESS;
    nd = 0; got = 0;
    for (int k = 0; k < 24 && !got; k++) begin
      settle();
      if (!dwait) nd++;
      if (!iwait) got = 1;
      adv();
    end
    chk("starve_ndata", nd, SL);
    chk("starve_fetch", 32'(got), 1);
    tick();
    settle();
    chk("starve_cnt_clr", 32'(dwait), 0);
    adv();
    iREN = 0; dREN = 0;
    tick();

    // stalled read times out on the last allowed granted cycle
    dREN = 1; ramstate = BUSY; daddr = 32'h300;
    tick();
    for (int g = 1; g <= TO; g++) begin
      settle();
      chk("to_derr", 32'(derr), (g == TO) ? 1 : 0);
      chk("to_ren", 32'(ramREN), (g == TO) ? 0 : 1);
      adv();
    end
    dREN = 0;
    settle();
    chk("to_after_derr", 32'(derr), 0);
    adv();

    // RAM error on a fetch
    iREN = 1;
    tick();
    ramstate = ERROR;
    settle();
    chk("err_ierr", 32'(ierr), 1);
    chk("err_iwait", 32'(iwait), 1);
    adv();
    settle();
    chk("err_ierr_off", 32'(ierr), 0);
    chk("err_idle_ren", 32'(ramREN), 0);
    adv();
    iREN = 0; ramstate = BUSY;
    tick();
    tick();

    // fetch withdrawn mid-access, then a waiting read wins
    iREN = 1;
    tick();
    tick();
    iREN = 0; dREN = 1; daddr = 32'h404;
    settle();
    chk("ab_ren", 32'(ramREN), 0);
    chk("ab_iwait", 32'(iwait), 1);
    chk("ab_ierr", 32'(ierr), 0);
    adv();
    tick();
    settle();
    chk("ab_rd_ren", 32'(ramREN), 1);
    chk("ab_rd_addr", ramaddr, 32'h404);
    adv();
    dREN = 0;
    tick();

    // random traffic against the model
    for (int c = 0; c < 600; c++) begin
      iREN = ($urandom_range(0, 3) != 0);
      dREN = ($urandom_range(0, 2) == 0);
      dWEN = ($urandom_range(0, 3) == 0);
      iaddr = $urandom; daddr = $urandom;
      dstore = $urandom; ramload = $urandom;
      r = $urandom_range(0, 9);
      ramstate = (r < 5) ? BUSY : (r < 8) ? ACCESS :
                 (r == 8) ? ERROR : FREE;
      settle();
      chk("excl_wait", 32'(iwait | dwait), 1);
      chk("excl_en", 32'(ramREN & ramWEN), 0);
      adv();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
